// File: rtl/fp_adder_arbiter.sv
// fp_adder_arbiter: round-robin front end that shares one pipelined IEEE single
// precision adder between NUM_REQ requesters. It issues at most one add/sub per
// cycle and tags each op with its requester ID so the result can be routed back.
// It also caps the number of in-flight ops per requester.
module fp_adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int LATENCY = 6,
  parameter int MAX_OUT = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ-1:0]      req_mode,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic                    add_mode,
  output logic [31:0]             add_a,
  output logic [31:0]             add_b,
  input  logic [31:0]             add_result,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_data,
  output logic                    busy
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  // Stage 0 sits beside the operand register; stage LATENCY lines up with the
  // cycle in which the adder presents the matching result.
  tag_t            tag_q [LATENCY+1];
  tag_t            tag_d [LATENCY+1];
  logic [CNT_W-1:0] cnt_q [NUM_REQ];
  logic [CNT_W-1:0] cnt_d [NUM_REQ];
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            add_mode_q, add_mode_d;
  logic [31:0]     add_a_q, add_a_d;
  logic [31:0]     add_b_q, add_b_d;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic               grant_found;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    cand;
  logic               retire;
  logic [ID_W-1:0]    retire_id;

  // A requester may compete only while it is below its in-flight cap.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] && (cnt_q[i] < CNT_MAX);
    end
  end

  // Round-robin search starting at the pointer; reset suppresses any grant.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = ID_W'((int'(ptr_q) + off) % NUM_REQ);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
    if (reset) begin
      grant_found = 1'b0;
    end
    if (grant_found) begin
      grant[grant_id] = 1'b1;
    end
  end

  assign req_ready = grant;
  assign retire    = tag_q[LATENCY].valid;
  assign retire_id = tag_q[LATENCY].id;

  // Next state for operands, pointer and the free-running tag shift register.
  always_comb begin
    ptr_d      = ptr_q;
    add_mode_d = 1'b0;
    add_a_d    = '0;
    add_b_d    = '0;
    tag_d[0]   = '0;
    for (int j = 1; j <= LATENCY; j++) begin
      tag_d[j] = tag_q[j-1];
    end
    if (grant_found) begin
      ptr_d          = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
      add_mode_d     = req_mode[grant_id];
      add_a_d        = req_a[int'(grant_id)*32 +: 32];
      add_b_d        = req_b[int'(grant_id)*32 +: 32];
      tag_d[0].valid = 1'b1;
      tag_d[0].id    = grant_id;
    end
  end

  // In-flight counters: issue and retire on the same edge cancel out.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if ((grant_found && grant_id == ID_W'(i)) && !(retire && retire_id == ID_W'(i))) begin
        if (cnt_q[i] != CNT_MAX) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else if ((retire && retire_id == ID_W'(i)) && !(grant_found && grant_id == ID_W'(i))) begin
        if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
      end
    end
  end

  // State registers; reset discards every in-flight op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q      <= '0;
      add_mode_q <= 1'b0;
      add_a_q    <= '0;
      add_b_q    <= '0;
      for (int j = 0; j <= LATENCY; j++) begin
        tag_q[j] <= '0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      ptr_q      <= ptr_d;
      add_mode_q <= add_mode_d;
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
      for (int j = 0; j <= LATENCY; j++) begin
        tag_q[j] <= tag_d[j];
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Busy while any tag stage still carries an op.
  always_comb begin
    busy = 1'b0;
    for (int j = 0; j <= LATENCY; j++) begin
      busy = busy | tag_q[j].valid;
    end
  end

  assign add_mode  = add_mode_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign rsp_valid = tag_q[LATENCY].valid;
  assign rsp_id    = tag_q[LATENCY].valid ? tag_q[LATENCY].id : '0;
  assign rsp_data  = add_result;

endmodule

// File: tb/tb_fp_adder_arbiter.sv
// tb_fp_adder_arbiter: directed bench for the shared FP adder arbiter, with a
// table-driven pipelined adder model standing in for the real adder.
module tb_fp_adder_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int LATENCY = 6;
  localparam int MAX_OUT = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_mode;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic                  add_mode;
  logic [31:0]           add_a;
  logic [31:0]           add_b;
  logic [31:0]           add_result;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_data;
  logic                  busy;

  int vectors     = 0;
  int miscompares = 0;

  fp_adder_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .LATENCY(LATENCY), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_a(req_a), .req_b(req_b),
    .add_mode(add_mode), .add_a(add_a), .add_b(add_b), .add_result(add_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Hand-computed single precision results for the operand pairs used here.
  function automatic logic [31:0] fpOp(input logic [31:0] a, input logic [31:0] b, input logic m);
    case ({m, a, b})
      {1'b0, 32'h3FC00000, 32'h40200000}: return 32'h40800000;
      {1'b1, 32'h40200000, 32'h3FC00000}: return 32'h3F800000;
      {1'b0, 32'hC0000000, 32'h40400000}: return 32'h3F800000;
      {1'b0, 32'h3F800000, 32'h3F800000}: return 32'h40000000;
      {1'b0, 32'h00000000, 32'h00000000}: return 32'h00000000;
      default:                           return 32'hDEADBEEF;
    endcase
  endfunction

  // Adder model: operands captured one edge after issue, result LATENCY-1 edges later.
  logic [31:0] pipe [LATENCY];
  always @(posedge clk) begin
    pipe[0] <= fpOp(add_a, add_b, add_mode);
    for (int j = 1; j < LATENCY; j++) pipe[j] <= pipe[j-1];
  end
  assign add_result = pipe[LATENCY-1];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] valid);
    req_valid = valid;
    #1;
  endtask

  task automatic setOperands(input int i, input logic [31:0] a, input logic [31:0] b, input logic m);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_mode[i]       = m;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic waitResponse(output int cycles);
    cycles = 0;
    while (!rsp_valid && cycles < 40) begin
      tick();
      cycles++;
    end
    if (!rsp_valid) checkOutput("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(busy), 32'd0);
  endtask

  function automatic logic cntViolation();
    logic bad = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (32'(dut.cnt_q[i]) > MAX_OUT) bad = 1'b1;
      if (rsp_valid && 32'(rsp_id) == i && dut.cnt_q[i] == 0) bad = 1'b1;
    end
    return bad;
  endfunction

  // Counter bounds watched every cycle: no overflow, no retire from zero.
  always @(negedge clk) begin
    if (reset === 1'b0) checkOutput("cnt_bound", 32'(cntViolation()), 32'd0);
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int c;
    int id;
    logic [31:0] rrExp [NUM_REQ];
    logic [16:0] readyPat;
    logic [16:0] rspPat;
    int seen;

    reset     = 1'b1;
    req_valid = '0;
    req_mode  = '0;
    req_a     = '0;
    req_b     = '0;
    applyStimulus('1);
    repeat (2) @(negedge clk);

    // reset state, with every requester asking
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_add_a", add_a, 32'd0);
    checkOutput("rst_add_b", add_b, 32'd0);
    checkOutput("rst_add_mode", 32'(add_mode), 32'd0);
    reset = 1'b0;
    applyStimulus('0);
    tick();

    // single add from requester 0
    setOperands(0, 32'h3FC00000, 32'h40200000, 1'b0);
    applyStimulus(4'b0001);
    checkOutput("t1_ready", 32'(req_ready), 32'h1);
    tick();
    applyStimulus(4'b0000);
    checkOutput("t1_add_a", add_a, 32'h3FC00000);
    checkOutput("t1_add_b", add_b, 32'h40200000);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    waitResponse(c);
    checkOutput("t1_latency", 32'(c), 32'(LATENCY));
    checkOutput("t1_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("t1_rsp_data", rsp_data, 32'h40800000);
    tick();
    checkOutput("t1_busy_after", 32'(busy), 32'd0);
    checkOutput("t1_rsp_after", 32'(rsp_valid), 32'd0);

    // subtract from requester 2
    setOperands(2, 32'h40200000, 32'h3FC00000, 1'b1);
    applyStimulus(4'b0100);
    checkOutput("t2_ready", 32'(req_ready), 32'h4);
    tick();
    applyStimulus(4'b0000);
    checkOutput("t2_add_mode", 32'(add_mode), 32'd1);
    waitResponse(c);
    checkOutput("t2_latency", 32'(c), 32'(LATENCY));
    checkOutput("t2_rsp_id", 32'(rsp_id), 32'd2);
    checkOutput("t2_rsp_data", rsp_data, 32'h3F800000);
    tick();

    // short reset pulse brings the pointer (now 3) back to 0
    reset = 1'b1;
    #1;
    checkOutput("pulse_ptr", 32'(dut.ptr_q), 32'd0);
    tick();
    reset = 1'b0;
    #1;

    // round robin with all four requesters asking continuously
    setOperands(0, 32'h3F800000, 32'h3F800000, 1'b0);
    setOperands(1, 32'hC0000000, 32'h40400000, 1'b0);
    setOperands(2, 32'h40200000, 32'h3FC00000, 1'b1);
    setOperands(3, 32'h3FC00000, 32'h40200000, 1'b0);
    rrExp[0] = 32'h40000000;
    rrExp[1] = 32'h3F800000;
    rrExp[2] = 32'h3F800000;
    rrExp[3] = 32'h40800000;
    applyStimulus(4'b1111);
    for (int n = 0; n < 12; n++) begin
      checkOutput($sformatf("rr_grant%0d", n), 32'(req_ready), 32'(1 << (n % 4)));
      if (n < 7) begin
        checkOutput($sformatf("rr_idle%0d", n), 32'(rsp_valid), 32'd0);
      end else begin
        id = (n - 7) % 4;
        checkOutput($sformatf("rr_rsp_valid%0d", n), 32'(rsp_valid), 32'd1);
        checkOutput($sformatf("rr_rsp_id%0d", n), 32'(rsp_id), 32'(id));
        checkOutput($sformatf("rr_rsp_data%0d", n), rsp_data, rrExp[id]);
      end
      tick();
    end
    applyStimulus(4'b0000);
    waitIdle("rr_drain");

    // outstanding cap with only requester 3 asking
    readyPat = 17'h10707;
    rspPat   = 17'h18380;
    applyStimulus(4'b1000);
    for (int n = 0; n < 17; n++) begin
      checkOutput($sformatf("cap_ready%0d", n), 32'(req_ready), readyPat[n] ? 32'h8 : 32'h0);
      checkOutput($sformatf("cap_rsp%0d", n), 32'(rsp_valid), 32'(rspPat[n]));
      if (rspPat[n]) begin
        checkOutput($sformatf("cap_rsp_id%0d", n), 32'(rsp_id), 32'd3);
        checkOutput($sformatf("cap_rsp_data%0d", n), rsp_data, 32'h40800000);
      end
      if (n == 7) checkOutput("cap_cnt_full", 32'(dut.cnt_q[3]), 32'd3);
      if (n == 8) checkOutput("cap_cnt_before_same", 32'(dut.cnt_q[3]), 32'd2);
      if (n == 9) checkOutput("cap_cnt_after_same", 32'(dut.cnt_q[3]), 32'd2);
      tick();
    end
    applyStimulus(4'b0000);
    waitIdle("cap_drain");

    // reset while three ops are in flight
    applyStimulus(4'b0111);
    checkOutput("mid_grant0", 32'(req_ready), 32'h1);
    tick();
    checkOutput("mid_grant1", 32'(req_ready), 32'h2);
    tick();
    checkOutput("mid_grant2", 32'(req_ready), 32'h4);
    tick();
    applyStimulus(4'b0000);
    checkOutput("mid_busy", 32'(busy), 32'd1);
    tick();
    tick();
    reset = 1'b1;
    applyStimulus(4'b1111);
    checkOutput("mid_rst_ready", 32'(req_ready), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_rsp", 32'(rsp_valid), 32'd0);
    checkOutput("mid_rst_ptr", 32'(dut.ptr_q), 32'd0);
    checkOutput("mid_rst_cnt", 32'(dut.cnt_q[0] | dut.cnt_q[1] | dut.cnt_q[2] | dut.cnt_q[3]), 32'd0);
    tick();
    reset = 1'b0;
    applyStimulus(4'b0000);
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      if (rsp_valid) seen++;
      tick();
    end
    checkOutput("mid_no_rsp", 32'(seen), 32'd0);
    checkOutput("mid_idle", 32'(busy), 32'd0);

    // first grant after reset goes to the lowest-index valid requester
    applyStimulus(4'b0110);
    checkOutput("post_rst_grant", 32'(req_ready), 32'h2);
    tick();
    applyStimulus(4'b0000);
    waitResponse(c);
    checkOutput("post_rst_latency", 32'(c), 32'(LATENCY));
    checkOutput("post_rst_id", 32'(rsp_id), 32'd1);
    checkOutput("post_rst_data", rsp_data, 32'h3F800000);
    waitIdle("final_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
